rv32i_multicycle_core: RTL and testbench

//  Multi-cycle RV32I integer core (RV32E via parameter) with a real FETCH/DECODE/EXEC/LOAD state machine.

---
 rtl/rv_pkg.sv | 67 ++++++
 rtl/rv_alu.sv | 38 +++
 rtl/rv32i_multicycle_core.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_core.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, funct3 codes,
// ALU operation enum, FSM state enum and the immediate generator.
package rv_pkg;

    // Opcodes carry an OPC_ prefix so that OPC_LOAD does not collide with the
    // LOAD FSM state.
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, LOAD, HALT} state_e;

    // Sign-extended immediate, format chosen by opcode (I-type by default).
    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] imm;
        case (i[6:0])
            OPC_STORE:          imm = {{20{i[31]}}, i[31:25], i[11:7]};
            OPC_BRANCH:         imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {i[31:12], 12'b0};
            OPC_JAL:            imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:            imm = {{20{i[31]}}, i[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational ALU for the multi-cycle core.
//   a, b    : operands
//   alu_op  : operation select
//   y       : result
//   eq/lt/ltu : a==b, signed a<b, unsigned a<b (branch conditions)
module rv_alu
    import rv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     alu_op,
    output logic [31:0] y,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        y = a + b;
        case (alu_op)
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, lt};
            ALU_SLTU: y = {31'b0, ltu};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I core (RV32E with NUM_REGS=16).
// FETCH -> DECODE -> EXEC (-> LOAD) -> FETCH; HALT on ECALL/EBREAK/trap.
// Ports:
//   clk, reset            : clock, async active-high reset
//   imem_addr/imem_rdata  : instruction port, 1-cycle synchronous read
//   dmem_addr/wdata/be/we/re/rdata : data port, 1-cycle synchronous read
//   leds                  : memory-mapped LED register at LED_ADDR
//   retire                : one-cycle pulse per completed instruction
//   halted, trap          : sticky stop / stop-was-a-fault flags
module rv32i_multicycle_core
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          LED_W    = 4,
    parameter logic [31:0] LED_ADDR = 32'hFFFF_FFF0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_be,
    output logic             dmem_we,
    output logic             dmem_re,
    input  logic [31:0]      dmem_rdata,
    output logic [LED_W-1:0] leds,
    output logic             retire,
    output logic             halted,
    output logic             trap
);

    localparam int RW = $clog2(NUM_REGS);

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d, instr_q, instr_d;
    logic [31:0]       rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              retire_q, retire_d, halted_q, halted_d, trap_q, trap_d;

    // Register file: no reset; entry 0 is never written and never read.
    logic [31:0]       rf_q [NUM_REGS];
    logic              rf_we;
    logic [31:0]       rf_wdata;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2, dec_rs1, dec_rs2;
    logic [2:0]  f3;
    assign opcode  = instr_q[6:0];
    assign rd      = instr_q[11:7];
    assign f3      = instr_q[14:12];
    assign rs1     = instr_q[19:15];
    assign rs2     = instr_q[24:20];
    assign f7      = instr_q[31:25];
    assign dec_rs1 = imem_rdata[19:15];
    assign dec_rs2 = imem_rdata[24:20];

    // ---------------- decode checks and ALU control ----------------
    logic    illegal, uses_rd, uses_rs1, uses_rs2;
    alu_op_e alu_op;

    always_comb begin
        illegal  = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                if (f3 == F3_SLL && f7 != 7'h00) illegal = 1'b1;
                if (f3 == F3_SR && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
            end
            OPC_OP: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR))))
                    illegal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rd = 1'b1;
            OPC_JALR: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                if (f3 != 3'b000) illegal = 1'b1;
            end
            OPC_LOAD: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (f3 > F3_W) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
            end
            OPC_FENCE:  if (f3 != 3'b000) illegal = 1'b1;
            OPC_SYSTEM: if (instr_q != INSTR_ECALL && instr_q != INSTR_EBREAK) illegal = 1'b1;
            default:    illegal = 1'b1;
        endcase
        // RV32E: any register field actually used by the format must exist.
        if ((uses_rd  && {27'b0, rd}  >= NUM_REGS) ||
            (uses_rs1 && {27'b0, rs1} >= NUM_REGS) ||
            (uses_rs2 && {27'b0, rs2} >= NUM_REGS))
            illegal = 1'b1;

        alu_op = ALU_ADD;
        if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (f3)
                // SUB only for register form; ADDI's upper imm bits sit in f7.
                F3_ADD:  alu_op = (opcode == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
                F3_SLL:  alu_op = ALU_SLL;
                F3_SLT:  alu_op = ALU_SLT;
                F3_SLTU: alu_op = ALU_SLTU;
                F3_XOR:  alu_op = ALU_XOR;
                F3_SR:   alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                F3_OR:   alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    // ---------------- datapath ----------------
    logic [31:0] alu_a, alu_b, alu_y, pc_plus4, br_tgt, jalr_tgt, ea;
    logic        eq, lt, ltu, taken, misaligned, is_led;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    assign alu_a = (opcode == OPC_AUIPC) ? pc_q :
                   (opcode == OPC_LUI)   ? 32'd0 : rs1_q;
    assign alu_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_q : imm_q;

    rv_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .y      (alu_y),
        .eq     (eq),
        .lt     (lt),
        .ltu    (ltu)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_q + imm_q;
    assign jalr_tgt = {alu_y[31:1], 1'b0};
    // rs1_q/imm_q hold through LOAD, so ea stays valid for lane selection.
    assign ea       = rs1_q + imm_q;
    assign misaligned = (f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    assign is_led   = ({ea[31:2], 2'b00} == LED_ADDR);

    always_comb begin
        case (f3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            default: taken = !ltu;
        endcase
    end

    assign dmem_addr = {ea[31:2], 2'b00};

    always_comb begin
        case (f3[1:0])
            2'b00: begin
                dmem_wdata = {4{rs2_q[7:0]}};
                dmem_be    = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{rs2_q[15:0]}};
                dmem_be    = ea[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dmem_wdata = rs2_q;
                dmem_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (ea[1:0])
            2'b00:   ld_b = dmem_rdata[7:0];
            2'b01:   ld_b = dmem_rdata[15:8];
            2'b10:   ld_b = dmem_rdata[23:16];
            default: ld_b = dmem_rdata[31:24];
        endcase
        ld_h = ea[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3)
            F3_B:    ld_val = {{24{ld_b[7]}}, ld_b};
            F3_H:    ld_val = {{16{ld_h[15]}}, ld_h};
            F3_BU:   ld_val = {24'b0, ld_b};
            F3_HU:   ld_val = {16'b0, ld_h};
            default: ld_val = dmem_rdata;
        endcase
    end

    // ---------------- FSM next-state / outputs ----------------
    logic        do_trap;
    logic [31:0] jmp_tgt;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        leds_d   = leds_q;
        retire_d = 1'b0;
        halted_d = halted_q;
        trap_d   = trap_q;
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        dmem_we  = 1'b0;
        dmem_re  = 1'b0;
        do_trap  = 1'b0;
        jmp_tgt  = (opcode == OPC_JAL) ? br_tgt : jalr_tgt;

        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                instr_d = imem_rdata;
                rs1_d   = (dec_rs1 == 5'd0) ? 32'd0 : rf_q[dec_rs1[RW-1:0]];
                rs2_d   = (dec_rs2 == 5'd0) ? 32'd0 : rf_q[dec_rs2[RW-1:0]];
                imm_d   = imm_gen(imem_rdata);
                state_d = EXEC;
            end
            EXEC: begin
                state_d  = FETCH;
                pc_d     = pc_plus4;
                retire_d = 1'b1;
                if (illegal) begin
                    do_trap = 1'b1;
                end else begin
                    case (opcode)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: rf_we = 1'b1;
                        OPC_JAL, OPC_JALR: begin
                            if (jmp_tgt[1]) begin
                                do_trap = 1'b1;
                            end else begin
                                rf_we    = 1'b1;
                                rf_wdata = pc_plus4;
                                pc_d     = jmp_tgt;
                            end
                        end
                        OPC_BRANCH: begin
                            if (taken) begin
                                if (br_tgt[1]) do_trap = 1'b1;
                                else           pc_d = br_tgt;
                            end
                        end
                        OPC_LOAD: begin
                            if (misaligned) begin
                                do_trap = 1'b1;
                            end else begin
                                dmem_re  = 1'b1;
                                state_d  = LOAD;
                                pc_d     = pc_q;
                                retire_d = 1'b0;
                            end
                        end
                        OPC_STORE: begin
                            if (misaligned)  do_trap = 1'b1;
                            else if (is_led) leds_d  = dmem_wdata[LED_W-1:0];
                            else             dmem_we = 1'b1;
                        end
                        OPC_SYSTEM: begin
                            halted_d = 1'b1;
                            state_d  = HALT;
                            pc_d     = pc_q;
                            retire_d = 1'b0;
                        end
                        default: ; // FENCE: plain pc+4
                    endcase
                end
                // Any fault leaves architectural state untouched.
                if (do_trap) begin
                    trap_d   = 1'b1;
                    halted_d = 1'b1;
                    state_d  = HALT;
                    pc_d     = pc_q;
                    retire_d = 1'b0;
                    rf_we    = 1'b0;
                    dmem_we  = 1'b0;
                    dmem_re  = 1'b0;
                    leds_d   = leds_q;
                end
            end
            LOAD: begin
                rf_we    = 1'b1;
                rf_wdata = ld_val;
                pc_d     = pc_plus4;
                retire_d = 1'b1;
                state_d  = FETCH;
            end
            HALT:    ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            leds_q   <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            leds_q   <= leds_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    // rf_we derives from state_q, which reset forces to FETCH, so an
    // in-flight write is dropped as soon as reset rises.
    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0) rf_q[rd[RW-1:0]] <= rf_wdata;
    end

    assign imem_addr = pc_q;
    assign leds      = leds_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign trap      = trap_q;

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Self-checking bench for rv32i_multicycle_core. Small programs are placed in
// an instruction ROM model; each program reports results through stores,
// whose expected address/data/byte-enables are queued up front and compared
// as the core issues them.
module tb_rv32i_multicycle_core;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FFF0;
    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111,
                           AUI = 7'b0010111, JALR = 7'b1100111, LDO = 7'b0000011;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_we, dmem_re, retire, halted, trap;
    logic [3:0]  leds;

    rv32i_multicycle_core #(.RESET_PC(RESET_PC), .NUM_REGS(32), .LED_W(4), .LED_ADDR(LED_ADDR)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .leds(leds), .retire(retire), .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    // Memory models: 1-cycle synchronous read.
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    always @(posedge clk) imem_rdata <= imem[imem_addr[9:2]];
    always @(posedge clk) begin
        if (dmem_re) dmem_rdata <= dmem[dmem_addr[9:2]];
        if (dmem_we)
            for (int b = 0; b < 4; b++)
                if (dmem_be[b]) dmem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end

    int nchk = 0, errs = 0, nreads = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;
    st_t sb_q[$];

    function automatic void push(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_t e;
        e.tag = tag; e.addr = a; e.data = d; e.be = be;
        sb_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (dmem_re) nreads++;
            if (dmem_we) begin
                chk("store_pending", {31'b0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    st_t e;
                    e = sb_q.pop_front();
                    chk({e.tag, "_addr"}, dmem_addr, e.addr);
                    chk({e.tag, "_data"}, dmem_wdata, e.data);
                    chk({e.tag, "_be"}, {28'b0, dmem_be}, {28'b0, e.be});
                end
            end
        end
    end

    // Encoders
    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = imm[11:0];
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OPR};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return i_t(imm, rs1, 0, rd, OPI);
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        return s_t(imm, rs2, rs1, 2);
    endfunction

    task automatic clr();
        for (int k = 0; k < 256; k++) imem[k] = ECALL;
    endtask
    task automatic p(input int a, input logic [31:0] w);
        imem[a >> 2] = w;
    endtask

    // Reset, release, optionally check first-retire latency, then run to halt.
    task automatic run_prog(input string name, input int lat, input logic exp_trap);
        int cyc;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        if (lat > 0) begin
            cyc = 0;
            while (!retire && !halted && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk({name, "_lat"}, 32'(cyc), 32'(lat));
            chk({name, "_pc1"}, imem_addr, RESET_PC + 32'd4);
        end
        cyc = 0;
        while (!halted && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_halted"}, {31'b0, halted}, 32'd1);
        chk({name, "_trap"}, {31'b0, trap}, {31'b0, exp_trap});
        chk({name, "_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int r0;
        clr();
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", imem_addr, RESET_PC);
        chk("rst_leds", {28'b0, leds}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_re", {31'b0, dmem_re}, 32'd0);

        // 1: ADDI latency and result
        clr();
        p(0, addi(1, 0, -5));
        p(4, sw(1, 0, 'h40));
        push("p1", 32'h40, 32'hFFFF_FFFB, 4'hF);
        run_prog("p1", 3, 1'b0);

        // Load latency
        clr();
        p(0, i_t('h10, 0, 2, 11, LDO));
        run_prog("ld", 4, 1'b0);

        // 2: byte/half stores and loads
        clr();
        p('h00, addi(2, 0, 'h80));
        p('h04, s_t('h11, 2, 0, 0));
        p('h08, i_t('h11, 0, 0, 3, LDO));
        p('h0C, i_t('h11, 0, 4, 4, LDO));
        p('h10, sw(3, 0, 'h40));
        p('h14, sw(4, 0, 'h44));
        p('h18, s_t('h22, 2, 0, 1));
        p('h1C, i_t('h22, 0, 1, 5, LDO));
        p('h20, sw(5, 0, 'h48));
        p('h24, addi(6, 0, -1));
        p('h28, s_t('h26, 6, 0, 1));
        p('h2C, i_t('h26, 0, 1, 7, LDO));
        p('h30, i_t('h26, 0, 5, 8, LDO));
        p('h34, sw(7, 0, 'h4C));
        p('h38, sw(8, 0, 'h50));
        push("sb", 32'h10, 32'h8080_8080, 4'b0010);
        push("lb", 32'h40, 32'hFFFF_FF80, 4'hF);
        push("lbu", 32'h44, 32'h0000_0080, 4'hF);
        push("sh", 32'h20, 32'h0080_0080, 4'b1100);
        push("lh_pos", 32'h48, 32'h0000_0080, 4'hF);
        push("sh_neg", 32'h24, 32'hFFFF_FFFF, 4'b1100);
        push("lh_neg", 32'h4C, 32'hFFFF_FFFF, 4'hF);
        push("lhu", 32'h50, 32'h0000_FFFF, 4'hF);
        run_prog("p2", 3, 1'b0);

        // 3: jumps and branches
        clr();
        p('h00, addi(1, 0, 1));
        p('h04, addi(6, 0, 'h100));
        p('h08, j_t('h18, 0));
        p('h18, i_t(1, 6, 0, 5, JALR));
        p('h20, b_t(-8, 0, 1, 1));
        p('h100, sw(5, 0, 'h40));
        p('h104, addi(8, 0, -1));
        p('h108, b_t(8, 8, 1, 6));
        p('h110, b_t(8, 8, 1, 4));
        p('h114, sw(1, 0, 'h44));
        push("jalr_link", 32'h40, 32'h0000_001C, 4'hF);
        push("blt_nt", 32'h44, 32'h0000_0001, 4'hF);
        run_prog("p3", 3, 1'b0);
        chk("p3_halt_pc", imem_addr, 32'h118);

        // 4: ALU corners
        clr();
        p('h00, {20'h80000, 5'd8, LUI});
        p('h04, i_t('h404, 8, 5, 7, OPI));
        p('h08, sw(7, 0, 'h40));
        p('h0C, i_t(-1, 0, 3, 9, OPI));
        p('h10, sw(9, 0, 'h44));
        p('h14, addi(0, 0, 7));
        p('h18, sw(0, 0, 'h48));
        p('h1C, addi(1, 0, 5));
        p('h20, addi(2, 0, 7));
        p('h24, r_t('h20, 2, 1, 0, 3));
        p('h28, sw(3, 0, 'h4C));
        p('h2C, r_t(0, 1, 3, 2, 4));
        p('h30, sw(4, 0, 'h50));
        p('h34, r_t(0, 1, 3, 3, 5));
        p('h38, sw(5, 0, 'h54));
        p('h3C, i_t(4, 8, 5, 6, OPI));
        p('h40, sw(6, 0, 'h58));
        p('h44, {20'h00001, 5'd10, AUI});
        p('h48, sw(10, 0, 'h5C));
        push("srai", 32'h40, 32'hF800_0000, 4'hF);
        push("sltiu", 32'h44, 32'h1, 4'hF);
        push("x0", 32'h48, 32'h0, 4'hF);
        push("sub", 32'h4C, 32'hFFFF_FFFE, 4'hF);
        push("slt", 32'h50, 32'h1, 4'hF);
        push("sltu", 32'h54, 32'h0, 4'hF);
        push("srli", 32'h58, 32'h0800_0000, 4'hF);
        push("auipc", 32'h5C, 32'h0000_1044, 4'hF);
        run_prog("p4", 3, 1'b0);

        // 5: LED store, then misaligned LW
        clr();
        p('h00, addi(10, 0, -16));
        p('h04, addi(1, 0, 'hA));
        p('h08, sw(1, 10, 0));
        p('h0C, i_t(2, 0, 2, 2, LDO));
        r0 = nreads;
        run_prog("p5", 3, 1'b1);
        chk("p5_leds", {28'b0, leds}, 32'hA);
        chk("p5_reads", 32'(nreads - r0), 32'd0);
        chk("p5_pc", imem_addr, 32'h0C);

        // 6: reset during LOAD aborts the rd write
        clr();
        p('h00, addi(3, 0, 'h55));
        p('h04, i_t('h80, 0, 2, 3, LDO));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("p6_re_exec", {31'b0, dmem_re}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("p6_pc_rst", imem_addr, RESET_PC);
        chk("p6_re_rst", {31'b0, dmem_re}, 32'd0);
        chk("p6_retire_rst", {31'b0, retire}, 32'd0);
        chk("p6_leds_rst", {28'b0, leds}, 32'd0);
        clr();
        p('h00, sw(3, 0, 'h40));
        push("rd_kept", 32'h40, 32'h0000_0055, 4'hF);
        run_prog("p6", 3, 1'b0);

        // Illegal opcode 0x7F
        clr();
        p('h00, addi(1, 0, 9));
        p('h04, 32'h0000_007F);
        p('h08, sw(1, 0, 'h40));
        run_prog("p7", 3, 1'b1);
        chk("p7_pc", imem_addr, 32'h04);

        // Illegal funct7 on ADD
        clr();
        p('h00, r_t(1, 2, 1, 0, 3));
        run_prog("p8", 0, 1'b1);
        chk("p8_pc", imem_addr, 32'h00);

        // JAL target with bit1 set
        clr();
        p('h00, j_t(6, 1));
        run_prog("p9", 0, 1'b1);
        chk("p9_pc", imem_addr, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
        $finish;
    end

endmodule
